// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serial transmitter.
// Holds the FSM state encoding and the counter width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;

  // Bits needed to count 0..n-1; never less than one bit so a
  // degenerate counter (n == 1) still has a legal vector width.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tick_gen.sv
// Bit-hold timer: counts PRESCALE enabled cycles and flags the last one.
// tick is decoded from the registered count, so it carries no input-to-output path except enable.
module piso_tick_gen
  import piso_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_w(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_register_piso_tx.sv
// Parallel-in serial-out transmitter with selectable bit order, per-bit hold
// time (PRESCALE), abort, and a one-cycle done pulse after each word.
module shift_register_piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  input  logic             abort,
  output logic             load_ready,
  output logic             s_out,
  output logic             busy,
  output logic             done,
  output piso_state_e      state_dbg
);

  // Handshake: a word transfers on a rising edge where load_valid && load_ready;
  // load_ready is high only in IDLE, and abort in the same cycle blocks the transfer.

  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  piso_state_e      state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             msb_q, msb_n;
  logic             tick;

  piso_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state != SHIFT),
    .enable(state == SHIFT),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      msb_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      msb_q   <= msb_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    msb_n     = msb_q;
    unique case (state)
      IDLE: begin
        if (!abort && load_valid) begin
          sr_n      = load_data;
          msb_n     = msb_first;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          sr_n      = '0;
          bit_cnt_n = '0;
          state_n   = IDLE;
        end else if (tick) begin
          // Shift toward whichever end drives s_out, zero-filling behind.
          sr_n = msb_q ? (sr << 1) : (sr >> 1);
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
            state_n   = DONE;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      DONE: begin
        sr_n      = '0;
        bit_cnt_n = '0;
        state_n   = IDLE;
      end
      default: begin
        sr_n      = '0;
        bit_cnt_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign s_out      = (state == SHIFT) && (msb_q ? sr[WIDTH-1] : sr[0]);
  assign state_dbg  = state;

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Directed bench for shift_register_piso_tx: a PRESCALE=1 and a PRESCALE=3
// instance, table of words with hand-computed serial sequences plus corner sequences.
module tb_shift_register_piso_tx;
  import piso_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        lv1 = 1'b0, msb1 = 1'b0, ab1 = 1'b0;
  logic [7:0]  ld1 = '0;
  logic        lr1, so1, bz1, dn1;
  piso_state_e st1;

  logic        lv3 = 1'b0, msb3 = 1'b0, ab3 = 1'b0;
  logic [7:0]  ld3 = '0;
  logic        lr3, so3, bz3, dn3;
  piso_state_e st3;

  shift_register_piso_tx #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_data(ld1), .msb_first(msb1),
    .abort(ab1), .load_ready(lr1), .s_out(so1), .busy(bz1), .done(dn1), .state_dbg(st1)
  );

  shift_register_piso_tx #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .load_valid(lv3), .load_data(ld3), .msb_first(msb3),
    .abort(ab3), .load_ready(lr3), .s_out(so3), .busy(bz3), .done(dn3), .state_dbg(st3)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // seq holds the expected serial stream, first transmitted bit in seq[7].
  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs[6];

  task automatic send1(input int idx, input logic [7:0] d, input logic m, input logic [7:0] seq);
    @(negedge clk);
    check($sformatf("v%0d_ready_before", idx), lr1, 1);
    lv1 = 1'b1; ld1 = d; msb1 = m;
    @(negedge clk);
    lv1 = 1'b0; ld1 = '0;
    check($sformatf("v%0d_busy", idx), bz1, 1);
    check($sformatf("v%0d_ready_low", idx), lr1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("v%0d_bit%0d", idx, i), so1, seq[7-i]);
    end
    @(negedge clk);
    check($sformatf("v%0d_done", idx), dn1, 1);
    check($sformatf("v%0d_done_sout", idx), so1, 0);
    check($sformatf("v%0d_done_busy", idx), bz1, 1);
    @(negedge clk);
    check($sformatf("v%0d_done_clear", idx), dn1, 0);
    check($sformatf("v%0d_ready_after", idx), lr1, 1);
  endtask

  initial begin
    logic [7:0] w;
    logic       seen;

    vecs[0] = '{data: 8'h01, msb: 1'b0, seq: 8'h80};
    vecs[1] = '{data: 8'h01, msb: 1'b1, seq: 8'h01};
    vecs[2] = '{data: 8'hC8, msb: 1'b0, seq: 8'h13};
    vecs[3] = '{data: 8'hF0, msb: 1'b1, seq: 8'hF0};
    vecs[4] = '{data: 8'h96, msb: 1'b0, seq: 8'h69};
    vecs[5] = '{data: 8'h3C, msb: 1'b1, seq: 8'h3C};

    // Reset state
    #12;
    check("rst_ready", lr1, 1);
    check("rst_busy", bz1, 0);
    check("rst_done", dn1, 0);
    check("rst_sout", so1, 0);
    check("rst_state", st1, IDLE);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) send1(i, vecs[i].data, vecs[i].msb, vecs[i].seq);

    // Back-to-back with load_valid held; data changes mid-word must be ignored.
    @(negedge clk);
    lv1 = 1'b1; ld1 = 8'hA5; msb1 = 1'b1;
    @(negedge clk);
    ld1 = 8'h3C;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("b2b_first_bit%0d", i), so1, w[7-i]);
    end
    @(negedge clk);
    check("b2b_done", dn1, 1);
    @(negedge clk);
    check("b2b_ready", lr1, 1);
    @(negedge clk);
    lv1 = 1'b0;
    w = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("b2b_second_bit%0d", i), so1, w[7-i]);
    end
    @(negedge clk);
    check("b2b_second_done", dn1, 1);

    // PRESCALE=3: 8'hF0 LSB first -> 12 cycles of 0, 12 of 1, done at k+25.
    @(negedge clk);
    lv3 = 1'b1; ld3 = 8'hF0; msb3 = 1'b0;
    @(negedge clk);
    lv3 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("p3_c%0d", c), so3, (c > 12) ? 1 : 0);
    end
    check("p3_no_early_done", dn3, 0);
    @(negedge clk);
    check("p3_done", dn3, 1);
    @(negedge clk);
    check("p3_ready", lr3, 1);
    check("p3_done_clear", dn3, 0);

    // Abort at edge k+4.
    @(negedge clk);
    lv1 = 1'b1; ld1 = 8'hFF; msb1 = 1'b0;
    @(negedge clk);
    lv1 = 1'b0;
    check("abort_bit0", so1, 1);
    repeat (3) @(negedge clk);
    ab1 = 1'b1;
    @(negedge clk);
    ab1 = 1'b0;
    check("abort_sout", so1, 0);
    check("abort_ready", lr1, 1);
    check("abort_busy", bz1, 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dn1) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    // Abort and load_valid together in IDLE: abort wins.
    @(negedge clk);
    ab1 = 1'b1; lv1 = 1'b1; ld1 = 8'hFF;
    @(negedge clk);
    ab1 = 1'b0; lv1 = 1'b0;
    check("idle_abort_ready", lr1, 1);
    check("idle_abort_busy", bz1, 0);

    // Reset mid-word at k+3, then accept on the first edge after release.
    @(negedge clk);
    lv1 = 1'b1; ld1 = 8'hFF; msb1 = 1'b0;
    @(negedge clk);
    lv1 = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid_sout", so1, 0);
    check("rstmid_busy", bz1, 0);
    check("rstmid_ready", lr1, 1);
    check("rstmid_done", dn1, 0);
    @(negedge clk);
    reset = 1'b1;
    lv1 = 1'b1; ld1 = 8'h01; msb1 = 1'b0;
    @(negedge clk);
    lv1 = 1'b0;
    check("post_rst_accept_busy", bz1, 1);
    check("post_rst_bit0", so1, 1);
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (dn1) seen = 1'b1;
    end
    check("post_rst_no_stale_done", seen, 0);
    @(negedge clk);
    check("post_rst_done", dn1, 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_register_piso_tx.md
SHIFT_REGISTER_PISO_TX -- requirements
Module: shift_register_piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning number of bits per word (legal range 2..32).
REQ-002 SHALL have parameter PRESCALE, default 1, meaning clocks each serial bit is held (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_valid  input  1  parallel word offered.
REQ-006 SHALL have port load_data  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port msb_first  input  1  bit order, sampled with load_data (1 = MSB first, 0 = LSB first).
REQ-008 SHALL have port abort  input  1  synchronous cancel of the current word.
REQ-009 SHALL have port load_ready  output  1  block can accept a word.
REQ-010 SHALL have port s_out  output  1  registered serial data.
REQ-011 SHALL have port busy  output  1  word in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered or decoded from registered state only.
REQ-014 In IDLE: load_ready=1, busy=0, s_out=0, done=0.
REQ-015 Accept: load_valid && load_ready at edge k captures load_data, msb_first, clears bit and prescale counters, enters SHIFT at k+1.
REQ-016 In SHIFT: s_out = MSB of shift register if captured msb_first=1, else LSB; load_ready=0, busy=1.
REQ-017 Each bit SHALL be held exactly PRESCALE cycles; at end of hold, shift register shifts one place toward the output end, zero-filled, and bit counter increments.
REQ-018 After WIDTH bits held, SHALL enter DONE: done=1, busy=1, s_out=0, load_ready=0, for exactly one cycle, then IDLE.
REQ-019 Timing: bit i (0-based) on s_out cycles k+1+i*PRESCALE .. k+(i+1)*PRESCALE; done at k+WIDTH*PRESCALE+1; load_ready at k+WIDTH*PRESCALE+2.
REQ-020 load_valid while not in IDLE SHALL be ignored; no capture, no side effect.
REQ-021 load_valid held high continuously SHALL yield back-to-back words with exactly one DONE cycle between them.
REQ-022 abort sampled high in SHIFT or DONE: next cycle IDLE, s_out=0, no done pulse; abort has priority over all other transitions.
REQ-023 abort and load_valid both high in IDLE: abort wins, word not accepted.
REQ-024 Counters SHALL be sized ceil(log2) of WIDTH and PRESCALE; no wrap-around permitted within a word.
REQ-025 PRESCALE=1 SHALL produce one bit per clock with no idle gap between bits.

Reset
REQ-026 reset low SHALL immediately force IDLE, shift register and counters to 0, s_out=0, busy=0, done=0, load_ready=1, regardless of clock.
REQ-027 reset low mid-word SHALL discard the word; no done pulse on release.
REQ-028 First accept possible at first rising edge after reset deasserts.

Structure
REQ-029 Shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and default WIDTH/PRESCALE constants.
REQ-030 Bit-hold timing SHALL be one sub-module piso_tick_gen (prescale counter, clear input, tick output); all else in the top module.

Verification
REQ-031 WIDTH=8, PRESCALE=1, load 8'h01, msb_first=0 at edge k -> s_out 1 at k+1, 0 at k+2..k+8, done at k+9, load_ready at k+10.
REQ-032 Same with msb_first=1 -> s_out 0 at k+1..k+7, 1 at k+8, done at k+9.
REQ-033 PRESCALE=3, load 8'hF0, msb_first=0 -> s_out 0 for 12 cycles, then 1 for 12 cycles, done at k+25.
REQ-034 PRESCALE=1, load_valid held high with 8'hA5 then 8'h3C -> second accept at k+10, s_out 0,0,1,1,1,1,0,0 at k+11..k+18.
REQ-035 abort high at edge k+4 -> s_out 0 and load_ready 1 at k+5, no done pulse; reset low at k+3 of a fresh word -> same outputs immediately, no done after release.
